dmem_arbiter: RTL and testbench

Shares the single-port data memory between the single-cycle CPU and a debug/loader burst port. The CPU has priority. The debug port runs auto-incrementing read or write bursts of 1–16 beats, and a starvation limit guarantees it forward progress. The block sits between the CPU data-memory port and the data-memory macro, and stalls the CPU in any cycle where the debug port takes the memory.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_burst_ctrl.sv | 76 +++++++
 rtl/dmem_arbiter.sv | 82 ++++++++
 tb/tb_dmem_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter between the CPU and
// the debug/loader burst port.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Which port issued the read whose data returns in the following cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug-port and memory-macro signals of the data-memory arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_start;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [LEN_W-1:0]  dbg_len;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_busy;
  logic              dbg_done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dbg_start, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_busy, dbg_done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dbg_start, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_busy, dbg_done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_burst_ctrl.sv
// Debug burst sequencer: burst state, auto-incrementing address, remaining
// beat count, starvation counter and the completion pulse.
module dmem_burst_ctrl
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_start_i,
  input  burst_cmd_t        dbg_cmd_i,
  input  logic              dbg_gnt_i,
  output logic              dbg_pend_o,
  output logic              starve_max_o,
  output logic              burst_we_o,
  output logic [ADDR_W-1:0] burst_addr_o,
  output logic              dbg_done_o
);

  state_e            state_q, state_d;
  burst_cmd_t        cmd_q, cmd_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              done_q, done_d;

  // Next-state: cmd.len doubles as the remaining-beat counter
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    starve_d = starve_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        starve_d = '0;
        if (dbg_start_i) begin
          state_d = BURST;
          cmd_d   = dbg_cmd_i;
        end
      end
      BURST: begin
        if (dbg_gnt_i) begin
          cmd_d.addr = cmd_q.addr + ADDR_W'(1);
          cmd_d.len  = cmd_q.len - LEN_W'(1);
          starve_d   = '0;
          if (cmd_q.len == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
          starve_d = starve_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      starve_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      starve_q <= starve_d;
      done_q   <= done_d;
    end
  end

  assign dbg_pend_o   = (state_q == BURST);
  assign starve_max_o = (starve_q == CNT_W'(STARVE_LIMIT));
  assign burst_we_o   = cmd_q.we;
  assign burst_addr_o = cmd_q.addr;
  assign dbg_done_o   = done_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, debug bursts win when
// the CPU is idle or once the starvation limit is reached.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic              dbg_pend;
  logic              starve_max;
  logic              burst_we;
  logic [ADDR_W-1:0] burst_addr;
  logic              dbg_done;
  logic              dbg_win;
  logic              cpu_win;
  burst_cmd_t        dbg_cmd;
  owner_e            owner_q, owner_d;

  assign dbg_cmd = '{we: bus.dbg_we, addr: bus.dbg_addr, len: bus.dbg_len};

  dmem_burst_ctrl #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_burst_ctrl (
    .clk          (clk),
    .rst_n        (rst),
    .dbg_start_i  (bus.dbg_start),
    .dbg_cmd_i    (dbg_cmd),
    .dbg_gnt_i    (dbg_win),
    .dbg_pend_o   (dbg_pend),
    .starve_max_o (starve_max),
    .burst_we_o   (burst_we),
    .burst_addr_o (burst_addr),
    .dbg_done_o   (dbg_done)
  );

  assign dbg_win = dbg_pend && (!bus.cpu_req || starve_max);
  assign cpu_win = bus.cpu_req && !dbg_win;

  // Winner drives the macro; with no winner the CPU address is parked
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (dbg_win) begin
      bus.mem_we    = burst_we;
      bus.mem_addr  = burst_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end else if (cpu_win) begin
      bus.mem_we    = bus.cpu_we;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (dbg_win && !burst_we) begin
      owner_d = OWN_DBG;
    end else if (cpu_win && !bus.cpu_we) begin
      owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.dbg_gnt    = dbg_win;
  assign bus.cpu_stall  = bus.cpu_req && dbg_win;
  assign bus.dbg_busy   = dbg_pend;
  assign bus.dbg_done   = dbg_done;
  assign bus.dbg_rvalid = (owner_q == OWN_DBG);
  assign bus.dbg_rdata  = (owner_q == OWN_DBG) ? bus.mem_rdata : '0;
  assign bus.cpu_rdata  = (owner_q == OWN_CPU) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand-written
// reset sequences, against a behavioural 1-cycle-latency memory.
module tb_dmem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic       cr;
    logic       cw;
    logic [7:0] ca;
    logic [7:0] cd;
    logic       ds;
    logic       dw;
    logic [7:0] da;
    logic [3:0] dl;
    logic [7:0] dd;
  } in_t;

  typedef struct packed {
    logic       stall;
    logic       gnt;
    logic       mwe;
    logic [7:0] maddr;
    logic [7:0] mwd;
    logic [7:0] crd;
    logic       rv;
    logic [7:0] rd;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk;
  logic rst;
  logic [7:0] mem [256];
  vec_t vecs[$];
  int   n_total;
  int   n_pass;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data-memory macro: samples on the rising edge, read-first, 1-cycle latency
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  function automatic in_t mk_in(input logic cr, input logic cw, input logic [7:0] ca,
                                input logic [7:0] cd, input logic ds, input logic dw,
                                input logic [7:0] da, input logic [3:0] dl,
                                input logic [7:0] dd);
    in_t r;
    r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
    r.ds = ds; r.dw = dw; r.da = da; r.dl = dl; r.dd = dd;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic stall, input logic gnt, input logic mwe,
                                  input logic [7:0] maddr, input logic [7:0] mwd,
                                  input logic [7:0] crd, input logic rv,
                                  input logic [7:0] rd, input logic busy, input logic done);
    exp_t r;
    r.stall = stall; r.gnt = gnt; r.mwe = mwe; r.maddr = maddr; r.mwd = mwd;
    r.crd = crd; r.rv = rv; r.rd = rd; r.busy = busy; r.done = done;
    return r;
  endfunction

  task automatic add(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic apply_in(input in_t i);
    bus.cpu_req   = i.cr;
    bus.cpu_we    = i.cw;
    bus.cpu_addr  = i.ca;
    bus.cpu_wdata = i.cd;
    bus.dbg_start = i.ds;
    bus.dbg_we    = i.dw;
    bus.dbg_addr  = i.da;
    bus.dbg_len   = i.dl;
    bus.dbg_wdata = i.dd;
  endtask

  task automatic check_out(input string nm, input exp_t e);
    exp_t a;
    a.stall = bus.cpu_stall;
    a.gnt   = bus.dbg_gnt;
    a.mwe   = bus.mem_we;
    a.maddr = bus.mem_addr;
    a.mwd   = bus.mem_wdata;
    a.crd   = bus.cpu_rdata;
    a.rv    = bus.dbg_rvalid;
    a.rd    = bus.dbg_rdata;
    a.busy  = bus.dbg_busy;
    a.done  = bus.dbg_done;
    n_total++;
    if (a !== e) begin
      $display("FAIL %s: got stall/gnt/we/addr/wdata/crdata/rv/rdata/busy/done=%h want %h",
               nm, a, e);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle
  task automatic step(input in_t i, input exp_t e, input string nm);
    @(posedge clk);
    #1 apply_in(i);
    #3 check_out(nm, e);
  endtask

  initial begin
    in_t  z;
    exp_t ez;
    z  = '0;
    ez = '0;
    n_total = 0;
    n_pass  = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    apply_in(z);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_out("reset", ez);
    @(posedge clk);
    #3 rst = 1'b1;

    // CPU write then read
    add(mk_in(H,H,8'h10,8'h5A,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,H,8'h10,8'h5A,8'h00,L,8'h00,L,L));
    add(mk_in(H,L,8'h10,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h10,8'h00,8'h00,L,8'h00,L,L));
    add(z,                                           mk_exp(L,L,L,8'h00,8'h00,8'h5A,L,8'h00,L,L));
    // Debug write burst across the address wrap, CPU idle
    add(mk_in(L,L,8'h00,8'h00,H,H,8'hFE,4'h3,8'h00), ez);
    add(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h01), mk_exp(L,H,H,8'hFE,8'h01,8'h00,L,8'h00,H,L));
    add(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h02), mk_exp(L,H,H,8'hFF,8'h02,8'h00,L,8'h00,H,L));
    add(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h03), mk_exp(L,H,H,8'h00,8'h03,8'h00,L,8'h00,H,L));
    add(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h04), mk_exp(L,H,H,8'h01,8'h04,8'h00,L,8'h00,H,L));
    // Read burst started in the dbg_done cycle
    add(mk_in(L,L,8'h00,8'h00,H,L,8'hFE,4'h3,8'h00), mk_exp(L,L,L,8'h00,8'h00,8'h00,L,8'h00,L,H));
    add(z, mk_exp(L,H,L,8'hFE,8'h00,8'h00,L,8'h00,H,L));
    add(z, mk_exp(L,H,L,8'hFF,8'h00,8'h00,H,8'h01,H,L));
    add(z, mk_exp(L,H,L,8'h00,8'h00,8'h00,H,8'h02,H,L));
    add(z, mk_exp(L,H,L,8'h01,8'h00,8'h00,H,8'h03,H,L));
    add(z, mk_exp(L,L,L,8'h00,8'h00,8'h00,H,8'h04,L,H));
    add(z, ez);
    // Starvation: continuous CPU reads, len=1 debug read burst
    add(mk_in(H,L,8'h10,8'h00,H,L,8'hFE,4'h1,8'h00), mk_exp(L,L,L,8'h10,8'h00,8'h00,L,8'h00,L,L));
    for (int k = 0; k < 4; k++)
      add(mk_in(H,L,8'h10,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h10,8'h00,8'h5A,L,8'h00,H,L));
    add(mk_in(H,L,8'h10,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(H,H,L,8'hFE,8'h00,8'h5A,L,8'h00,H,L));
    add(mk_in(H,L,8'h10,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h10,8'h00,8'h00,H,8'h01,H,L));
    for (int k = 0; k < 3; k++)
      add(mk_in(H,L,8'h10,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h10,8'h00,8'h5A,L,8'h00,H,L));
    add(mk_in(H,L,8'h10,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(H,H,L,8'hFF,8'h00,8'h5A,L,8'h00,H,L));
    add(mk_in(H,L,8'h10,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h10,8'h00,8'h00,H,8'h02,L,H));
    add(z, mk_exp(L,L,L,8'h00,8'h00,8'h5A,L,8'h00,L,L));
    // dbg_start pulsed mid-burst must not reload address, length or direction
    add(mk_in(L,L,8'h00,8'h00,H,H,8'h20,4'h1,8'h00), ez);
    add(mk_in(L,L,8'h00,8'h00,H,L,8'h80,4'h5,8'hAA), mk_exp(L,H,H,8'h20,8'hAA,8'h00,L,8'h00,H,L));
    add(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'hBB), mk_exp(L,H,H,8'h21,8'hBB,8'h00,L,8'h00,H,L));
    add(z, mk_exp(L,L,L,8'h00,8'h00,8'h00,L,8'h00,L,H));
    add(z, ez);

    foreach (vecs[k]) step(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));

    // Reset mid-burst after two beats of a len=7 write burst
    step(mk_in(L,L,8'h00,8'h00,H,H,8'h40,4'h7,8'h00), ez, "rst_start");
    step(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h11), mk_exp(L,H,H,8'h40,8'h11,8'h00,L,8'h00,H,L), "rst_beat0");
    step(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h22), mk_exp(L,H,H,8'h41,8'h22,8'h00,L,8'h00,H,L), "rst_beat1");
    @(posedge clk);
    #1 apply_in(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h33));
    #1 rst = 1'b0;
    #1 check_out("rst_async", ez);
    apply_in(z);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #3 check_out($sformatf("rst_hold%0d", k), ez);
    end
    rst = 1'b1;
    step(mk_in(L,L,8'h00,8'h00,H,H,8'h50,4'h0,8'h00), ez, "new_start");
    step(mk_in(L,L,8'h00,8'h00,L,L,8'h00,4'h0,8'h77), mk_exp(L,H,H,8'h50,8'h77,8'h00,L,8'h00,H,L), "new_beat");
    step(z, mk_exp(L,L,L,8'h00,8'h00,8'h00,L,8'h00,L,H), "new_done");
    step(mk_in(H,L,8'h40,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h40,8'h00,8'h00,L,8'h00,L,L), "rd40");
    step(mk_in(H,L,8'h41,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h41,8'h00,8'h11,L,8'h00,L,L), "rd41");
    step(mk_in(H,L,8'h42,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h42,8'h00,8'h22,L,8'h00,L,L), "rd42");
    step(mk_in(H,L,8'h50,8'h00,L,L,8'h00,4'h0,8'h00), mk_exp(L,L,L,8'h50,8'h00,8'h00,L,8'h00,L,L), "rd50");
    step(z, mk_exp(L,L,L,8'h00,8'h00,8'h77,L,8'h00,L,L), "rd50_data");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
